// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - IF/MEM arbiter for the single byte-wide RAM port with registered read return.
// Optional grant-cycle counters (if_cycles, mem_cycles) enabled by defining MEM_CTRL_STAT_EN.
module mem_ctrl #(
  parameter int ADDR_WIDTH = 32
`ifdef MEM_CTRL_STAT_EN
  , parameter int STAT_WIDTH = 32
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  if_request,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic [1:0]            mem_request,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_data_i,
  output logic [7:0]            data_o,
  output logic [1:0]            if_or_mem,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr
`ifdef MEM_CTRL_STAT_EN
  , output logic [STAT_WIDTH-1:0] if_cycles
  , output logic [STAT_WIDTH-1:0] mem_cycles
`endif
);

  // Encoding matches the if_or_mem owner code directly.
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    IF_BUSY  = 2'b01,
    MEM_BUSY = 2'b10
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] data_q;
  logic       mem_req_valid;
  logic       src_mem;
  logic       src_if;

  assign mem_req_valid = (mem_request == 2'b01) || (mem_request == 2'b10);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else if (rdy) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mem_req_valid)   state_d = MEM_BUSY;
        else if (if_request) state_d = IF_BUSY;
      end
      IF_BUSY:  if (!if_request)    state_d = IDLE;
      MEM_BUSY: if (!mem_req_valid) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Port is driven from the active source in the same cycle; an owner whose request dropped drives nothing.
  always_comb begin
    src_mem  = (state_q == MEM_BUSY) || ((state_q == IDLE) && mem_req_valid);
    src_if   = (state_q == IF_BUSY) || ((state_q == IDLE) && !mem_req_valid && if_request);
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    if (src_mem && mem_req_valid) begin
      mem_a = mem_addr;
      if (mem_request == 2'b10) begin
        mem_dout = mem_data_i;
        mem_wr   = rdy && rst;
      end
    end else if (src_if && if_request) begin
      mem_a = if_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q <= '0;
    end else if (rdy) begin
      data_q <= mem_din;
    end
  end

  assign data_o    = data_q;
  assign if_or_mem = state_q;

`ifdef MEM_CTRL_STAT_EN
  logic [STAT_WIDTH-1:0] if_cycles_q;
  logic [STAT_WIDTH-1:0] mem_cycles_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      if_cycles_q  <= '0;
      mem_cycles_q <= '0;
    end else if (rdy) begin
      if (state_q == IF_BUSY)  if_cycles_q  <= if_cycles_q + 1'b1;
      if (state_q == MEM_BUSY) mem_cycles_q <= mem_cycles_q + 1'b1;
    end
  end

  assign if_cycles  = if_cycles_q;
  assign mem_cycles = mem_cycles_q;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed self-checking bench for mem_ctrl with a one-cycle-latency RAM model.
module tb_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst, rdy, if_request, mem_wr;
  logic [31:0] if_addr, mem_addr, mem_a;
  logic [1:0]  mem_request, if_or_mem;
  logic [7:0]  mem_data_i, data_o, mem_din, mem_dout;
`ifdef MEM_CTRL_STAT_EN
  logic [31:0] if_cycles, mem_cycles;
`endif

  logic [7:0] ram [0:65535];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_request(if_request), .if_addr(if_addr),
    .mem_request(mem_request), .mem_addr(mem_addr), .mem_data_i(mem_data_i),
    .data_o(data_o), .if_or_mem(if_or_mem),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
`ifdef MEM_CTRL_STAT_EN
    , .if_cycles(if_cycles), .mem_cycles(mem_cycles)
`endif
  );

  always @(posedge clk) begin
    if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
    mem_din <= ram[mem_a[15:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Four-byte IF burst starting from IDLE; exp_bytes holds the bytes, first one in the top byte.
  task automatic if_burst(input logic [31:0] base, input logic [31:0] exp_bytes);
    for (int c = 0; c < 6; c++) begin
      cyc();
      if_request = (c < 4);
      if_addr    = base + c;
      smp();
      if (c < 4) chk("if_a", mem_a, base + c);
      chk("if_own", {30'd0, if_or_mem}, (c == 0 || c == 5) ? 32'd0 : 32'd1);
      chk("if_wr", {31'd0, mem_wr}, 32'd0);
      if (c >= 2) chk("if_data", {24'd0, data_o}, {24'd0, exp_bytes[8*(5-c) +: 8]});
    end
    if_request = 1'b0;
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; if_request = 1'b0; if_addr = '0;
    mem_request = 2'b00; mem_addr = '0; mem_data_i = '0; mem_din = '0;
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h0100] = 8'h11; ram[16'h0101] = 8'h22; ram[16'h0102] = 8'h33; ram[16'h0103] = 8'h44;
    ram[16'h0400] = 8'h70; ram[16'h0401] = 8'h71; ram[16'h0402] = 8'h72; ram[16'h0403] = 8'h73;

    // Reset
    cyc(); cyc();
    rst = 1'b1;
    smp();
    chk("rst_own", {30'd0, if_or_mem}, 32'd0);
    chk("rst_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_a", mem_a, 32'd0);
    chk("rst_dout", {24'd0, mem_dout}, 32'd0);
    chk("rst_data", {24'd0, data_o}, 32'd0);

    // IF burst read
    if_burst(32'h100, 32'h11223344);

    // MEM store burst, then read back through IF
    for (int c = 0; c < 6; c++) begin
      cyc();
      mem_request = (c < 4) ? 2'b10 : 2'b00;
      mem_addr    = 32'h1000 + c;
      mem_data_i  = 8'hAA + 8'(8'h11 * c);
      smp();
      chk("st_wr", {31'd0, mem_wr}, (c < 4) ? 32'd1 : 32'd0);
      if (c < 4) begin
        chk("st_a", mem_a, 32'h1000 + c);
        chk("st_dout", {24'd0, mem_dout}, 32'hAA + 32'h11 * c);
      end
      chk("st_own", {30'd0, if_or_mem}, (c == 0 || c == 5) ? 32'd0 : 32'd2);
    end
    if_burst(32'h1000, 32'hAABBCCDD);

    // Simultaneous requests: MEM wins, one IDLE cycle, then IF
    cyc(); if_request = 1'b1; if_addr = 32'h100; mem_request = 2'b01; mem_addr = 32'h101; smp();
    chk("arb_a0", mem_a, 32'h101);
    chk("arb_own0", {30'd0, if_or_mem}, 32'd0);
    chk("arb_wr0", {31'd0, mem_wr}, 32'd0);
    cyc(); smp();
    chk("arb_own1", {30'd0, if_or_mem}, 32'd2);
    chk("arb_a1", mem_a, 32'h101);
    cyc(); mem_request = 2'b00; smp();
    chk("arb_own2", {30'd0, if_or_mem}, 32'd2);
    chk("arb_a2", mem_a, 32'd0);
    chk("arb_ld", {24'd0, data_o}, 32'h22);
    cyc(); smp();
    chk("arb_own3", {30'd0, if_or_mem}, 32'd0);
    chk("arb_a3", mem_a, 32'h100);
    cyc(); smp();
    chk("arb_own4", {30'd0, if_or_mem}, 32'd1);
    cyc(); if_request = 1'b0; smp();
    chk("arb_own5", {30'd0, if_or_mem}, 32'd1);
    chk("arb_if_data", {24'd0, data_o}, 32'h11);
    cyc(); smp();
    chk("arb_own6", {30'd0, if_or_mem}, 32'd0);

    // STORE raised during an IF burst waits for IF to release
    cyc(); if_request = 1'b1; if_addr = 32'h200; smp();
    chk("lock_own0", {30'd0, if_or_mem}, 32'd0);
    cyc(); if_addr = 32'h201; mem_request = 2'b10; mem_addr = 32'h300; mem_data_i = 8'h5A; smp();
    chk("lock_own1", {30'd0, if_or_mem}, 32'd1);
    chk("lock_wr1", {31'd0, mem_wr}, 32'd0);
    chk("lock_a1", mem_a, 32'h201);
    cyc(); if_addr = 32'h202; smp();
    chk("lock_wr2", {31'd0, mem_wr}, 32'd0);
    cyc(); if_request = 1'b0; smp();
    chk("lock_own3", {30'd0, if_or_mem}, 32'd1);
    chk("lock_wr3", {31'd0, mem_wr}, 32'd0);
    cyc(); smp();
    chk("lock_own4", {30'd0, if_or_mem}, 32'd0);
    chk("lock_wr4", {31'd0, mem_wr}, 32'd1);
    chk("lock_a4", mem_a, 32'h300);
    chk("lock_dout4", {24'd0, mem_dout}, 32'h5A);
    cyc(); mem_addr = 32'h301; mem_data_i = 8'h5B; smp();
    chk("lock_own5", {30'd0, if_or_mem}, 32'd2);
    chk("lock_wr5", {31'd0, mem_wr}, 32'd1);
    cyc(); mem_request = 2'b00; smp();
    chk("lock_wr6", {31'd0, mem_wr}, 32'd0);
    cyc(); smp();
    chk("lock_own7", {30'd0, if_or_mem}, 32'd0);

    // Stall with rdy=0 during a STORE
    cyc(); mem_request = 2'b10; mem_addr = 32'h400; mem_data_i = 8'h01; smp();
    chk("stall_wr0", {31'd0, mem_wr}, 32'd1);
    cyc(); mem_addr = 32'h401; mem_data_i = 8'h02; smp();
    chk("stall_own1", {30'd0, if_or_mem}, 32'd2);
    cyc(); mem_addr = 32'h402; mem_data_i = 8'h03; rdy = 1'b0; smp();
    chk("stall_wr2", {31'd0, mem_wr}, 32'd0);
    chk("stall_a2", mem_a, 32'h402);
    chk("stall_data2", {24'd0, data_o}, 32'h70);
    for (int c = 3; c < 5; c++) begin
      cyc(); smp();
      chk("stall_wr", {31'd0, mem_wr}, 32'd0);
      chk("stall_own", {30'd0, if_or_mem}, 32'd2);
      chk("stall_data", {24'd0, data_o}, 32'h70);
    end
    cyc(); rdy = 1'b1; smp();
    chk("stall_wr5", {31'd0, mem_wr}, 32'd1);
    chk("stall_a5", mem_a, 32'h402);
    chk("stall_dout5", {24'd0, mem_dout}, 32'h03);
    chk("stall_data5", {24'd0, data_o}, 32'h70);
    cyc(); mem_request = 2'b00; smp();
    chk("stall_own6", {30'd0, if_or_mem}, 32'd2);
    cyc(); smp();
    chk("stall_own7", {30'd0, if_or_mem}, 32'd0);
    if_burst(32'h400, 32'h01020373);

`ifdef MEM_CTRL_STAT_EN
    chk("stat_if", if_cycles, 32'd17);
    chk("stat_mem", mem_cycles, 32'd11);
`endif

    // Reset in the middle of a STORE
    cyc(); mem_request = 2'b10; mem_addr = 32'h500; mem_data_i = 8'h99; smp();
    chk("rmid_wr0", {31'd0, mem_wr}, 32'd1);
    cyc(); rst = 1'b0; smp();
    chk("rmid_wr1", {31'd0, mem_wr}, 32'd0);
    chk("rmid_own1", {30'd0, if_or_mem}, 32'd2);
    cyc(); rst = 1'b1; mem_request = 2'b00; smp();
    chk("rmid_own2", {30'd0, if_or_mem}, 32'd0);
    chk("rmid_data2", {24'd0, data_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
